stdby_responder: RTL and testbench
==================================

// Module: stdby_responder
// PURPOSE
//   Responder side of the standby handshake. Takes the one-cycle standby request pulse
//   made by the power-control edge detector (stdby_req) and quiesces the counter and
//   ADC logic through a req/ack handshake. It then drives the PCU standby line and
//   holds it for a minimum dwell time. Wake-up comes from a debounced external wake
//   pin, after which the block releases the logic back to RUN.
//   clk_osc (OSCH) stays running in standby; only downstream logic is quiesced.
// PARAMETERS
//   QUIESCE_TIMEOUT  1024  cycles allowed for quiesce_ack before abort (>=4)
//   MIN_STDBY        64    minimum cycles stdby stays high before a wake is honoured
//   WAKE_DEBOUNCE    16    consecutive low samples of synced wake_n needed to wake
//   RESUME_WAIT      32    settle cycles after stdby falls before unquiesce
// PORTS
//   clk_osc       in   1  internal oscillator clock
//   rst           in   1  asynchronous, active-low reset
//   stdby_req     in   1  standby request, 1-cycle pulse, clk_osc domain
//   wake_n        in   1  async wake pin, active low (2-FF synchronised here)
//   quiesce_ack   in   1  consumers idle; level, async (2-FF synchronised here)
//   quiesce_req   out  1  level; ask consumers to stop
//   stdby         out  1  standby request to PCU, registered
//   stdby_active  out  1  high while state == STDBY
//   wake_evt      out  1  1-cycle pulse when a wake is accepted
//   timeout_err   out  1  1-cycle pulse on quiesce timeout abort
// BEHAVIOUR
//   Reset (rst=0, async):
//   - all outputs 0, FSM=RUN, counters 0, synchronisers 1 for wake_n and 0 for ack.
//   - Reset mid-operation drops stdby and quiesce_req at once, with no clock edge.
//   FSM states: RUN, QUIESCE, ENTER, STDBY, WAKE, RESUME. All outputs are registered.
//   RUN:
//   - stdby_req=1 at edge N -> QUIESCE, quiesce_req=1 from N+1, counter cleared.
//   - stdby_req in any state other than RUN is ignored (not queued).
//   QUIESCE:
//   - counter +1 per cycle.
//   - Synced ack=1 -> ENTER.
//   - counter==QUIESCE_TIMEOUT-1 with no ack -> RUN, quiesce_req=0, timeout_err pulse.
//   - Ack and timeout on the same edge: ack wins.
//   ENTER:
//   - 1 cycle; sets stdby=1 -> STDBY. stdby rises 2 edges after synced ack is seen high.
//   STDBY:
//   - stdby=1, stdby_active=1; dwell counter saturates at MIN_STDBY.
//   - Debounce counter +1 while synced wake_n=0, cleared when it is 1, saturates at
//     WAKE_DEBOUNCE.
//   - Both counters saturated -> WAKE. A wake held low during dwell is honoured on the
//     first edge dwell completes.
//   WAKE:
//   - stdby=0, stdby_active=0, wake_evt=1 for 1 cycle.
//   - Counts RESUME_WAIT cycles -> RESUME.
//   RESUME:
//   - quiesce_req=0; wait for synced ack=0 -> RUN. No timeout here.
//   - stdby_req arriving in RESUME is ignored.
//   Counter widths: $clog2(param)+1. No counter may wrap; all saturate or clear on entry.
//   Synchronised wake_n deasserting in WAKE/RESUME does not change the sequence.
// TESTING
//   1 Reset: rst=0 then release -> all outputs 0, FSM RUN.
//   2 Nominal, defaults, ack tied to quiesce_req after 5 cycles:
//     - stdby_req@0 -> quiesce_req@1, stdby high 2 edges after synced ack.
//     - wake_n low 16 cycles after dwell -> wake_evt pulse.
//     - quiesce_req low after 32 cycles, then back in RUN.
//   3 Timeout: ack held 0 -> timeout_err pulse after 1024 QUIESCE cycles,
//     quiesce_req 0, stdby never 1.
//   4 Early wake: wake_n low from entry into STDBY -> wake_evt only after 64 cycles
//     in STDBY.
//   5 Bounce: wake_n low 15 cycles, high 1, low 15 -> no wake; 16 consecutive -> wake.
//   6 Reset mid-STDBY and stray stdby_req:
//     - rst=0 in STDBY -> stdby and quiesce_req 0 asynchronously.
//     - stdby_req pulsed during QUIESCE/RESUME -> no effect.

Source files
------------

// File: rtl/stdby_responder.sv
// Standby responder: quiesces downstream logic through a req/ack handshake, holds the
// PCU standby line for a minimum dwell and returns to RUN after a debounced wake.
module stdby_responder #(
  parameter int QUIESCE_TIMEOUT = 1024,
  parameter int MIN_STDBY       = 64,
  parameter int WAKE_DEBOUNCE   = 16,
  parameter int RESUME_WAIT     = 32
) (
  input  logic clk_osc,
  input  logic rst,
  input  logic i_stdby_req,
  input  logic i_wake_n,
  input  logic i_quiesce_ack,
  output logic o_quiesce_req,
  output logic o_stdby,
  output logic o_stdby_active,
  output logic o_wake_evt,
  output logic o_timeout_err
);

  localparam int QW = $clog2(QUIESCE_TIMEOUT) + 1;
  localparam int DW = $clog2(MIN_STDBY) + 1;
  localparam int BW = $clog2(WAKE_DEBOUNCE) + 1;
  localparam int RW = $clog2(RESUME_WAIT) + 1;

  localparam logic [QW-1:0] Q_LAST    = QW'(QUIESCE_TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_STDBY);
  localparam logic [BW-1:0] DEB_MAX   = BW'(WAKE_DEBOUNCE);
  localparam logic [RW-1:0] RES_LAST  = RW'(RESUME_WAIT - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_QUIESCE,
    S_ENTER,
    S_STDBY,
    S_WAKE,
    S_RESUME
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_wake_meta;
  logic r_wake_sync;
  logic r_ack_meta;
  logic r_ack_sync;

  logic [QW-1:0] r_q_cnt;
  logic [DW-1:0] r_dwell_cnt;
  logic [BW-1:0] r_deb_cnt;
  logic [RW-1:0] r_res_cnt;

  logic [QW-1:0] w_q_next;
  logic [DW-1:0] w_dwell_next;
  logic [BW-1:0] w_deb_next;
  logic [RW-1:0] w_res_next;
  logic [DW-1:0] w_dwell_inc;
  logic [BW-1:0] w_deb_inc;

  logic w_qreq_next;
  logic w_stdby_next;
  logic w_wake_evt_next;
  logic w_terr_next;

  // Idle wake pin reads high and an idle consumer reads not-acknowledged.
  always_ff @(posedge clk_osc or negedge rst) begin
    if (!rst) begin
      r_wake_meta <= 1'b1;
      r_wake_sync <= 1'b1;
      r_ack_meta  <= 1'b0;
      r_ack_sync  <= 1'b0;
    end else begin
      r_wake_meta <= i_wake_n;
      r_wake_sync <= r_wake_meta;
      r_ack_meta  <= i_quiesce_ack;
      r_ack_sync  <= r_ack_meta;
    end
  end

  assign w_dwell_inc = (r_dwell_cnt == DWELL_MAX) ? r_dwell_cnt : r_dwell_cnt + DW'(1);
  assign w_deb_inc   = r_wake_sync ? '0 :
                       ((r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + BW'(1));

  always_comb begin
    w_next       = r_state;
    w_q_next     = r_q_cnt;
    w_dwell_next = r_dwell_cnt;
    w_deb_next   = r_deb_cnt;
    w_res_next   = r_res_cnt;
    case (r_state)
      S_RUN: begin
        if (i_stdby_req) begin
          w_next   = S_QUIESCE;
          w_q_next = '0;
        end
      end
      S_QUIESCE: begin
        if (r_ack_sync) begin
          w_next = S_ENTER;
        end else if (r_q_cnt == Q_LAST) begin
          w_next = S_RUN;
        end else begin
          w_q_next = r_q_cnt + QW'(1);
        end
      end
      S_ENTER: begin
        w_next       = S_STDBY;
        w_dwell_next = '0;
        w_deb_next   = '0;
      end
      // Wake is judged on the updated counts, so a wake held through the dwell is
      // honoured on the very edge the dwell completes.
      S_STDBY: begin
        w_dwell_next = w_dwell_inc;
        w_deb_next   = w_deb_inc;
        if ((w_dwell_inc == DWELL_MAX) && (w_deb_inc == DEB_MAX)) begin
          w_next     = S_WAKE;
          w_res_next = '0;
        end
      end
      S_WAKE: begin
        if (r_res_cnt == RES_LAST) begin
          w_next = S_RESUME;
        end else begin
          w_res_next = r_res_cnt + RW'(1);
        end
      end
      S_RESUME: begin
        if (!r_ack_sync) begin
          w_next = S_RUN;
        end
      end
      default: begin
        w_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_qreq_next     = (w_next == S_QUIESCE) || (w_next == S_ENTER) ||
                      (w_next == S_STDBY)   || (w_next == S_WAKE);
    w_stdby_next    = (w_next == S_STDBY);
    w_wake_evt_next = (r_state == S_STDBY) && (w_next == S_WAKE);
    w_terr_next     = (r_state == S_QUIESCE) && (w_next == S_RUN);
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk_osc or negedge rst) begin
    if (!rst) begin
      r_state        <= S_RUN;
      r_q_cnt        <= '0;
      r_dwell_cnt    <= '0;
      r_deb_cnt      <= '0;
      r_res_cnt      <= '0;
      o_quiesce_req  <= 1'b0;
      o_stdby        <= 1'b0;
      o_stdby_active <= 1'b0;
      o_wake_evt     <= 1'b0;
      o_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_q_cnt        <= w_q_next;
      r_dwell_cnt    <= w_dwell_next;
      r_deb_cnt      <= w_deb_next;
      r_res_cnt      <= w_res_next;
      o_quiesce_req  <= w_qreq_next;
      o_stdby        <= w_stdby_next;
      o_stdby_active <= w_stdby_next;
      o_wake_evt     <= w_wake_evt_next;
      o_timeout_err  <= w_terr_next;
    end
  end

endmodule

// File: tb/tb_stdby_responder.sv
// Bench for stdby_responder: table of timed steps through a full standby cycle plus
// hand-written sequences for timeout, early wake, wake bounce and mid-standby reset.
module tb_stdby_responder;

  typedef struct {
    string      name;
    logic       req;
    logic       wakeN;
    int         cycles;
    logic [4:0] exp;
  } vec_t;

  logic clk_osc = 1'b0;
  logic rst = 1'b1;
  logic iStdbyReq = 1'b0;
  logic iWakeN = 1'b1;
  logic iQuiesceAck = 1'b0;
  logic oQuiesceReq;
  logic oStdby;
  logic oStdbyActive;
  logic oWakeEvt;
  logic oTimeoutErr;

  logic       ackEn = 1'b1;
  logic [4:0] ackSr = '0;

  int checks = 0;
  int passes = 0;
  int n;
  int wakes;
  logic sawStdby;
  vec_t vecs[11];

  stdby_responder dut (
    .clk_osc        (clk_osc),
    .rst            (rst),
    .i_stdby_req    (iStdbyReq),
    .i_wake_n       (iWakeN),
    .i_quiesce_ack  (iQuiesceAck),
    .o_quiesce_req  (oQuiesceReq),
    .o_stdby        (oStdby),
    .o_stdby_active (oStdbyActive),
    .o_wake_evt     (oWakeEvt),
    .o_timeout_err  (oTimeoutErr)
  );

  always #5 clk_osc = ~clk_osc;

  // Consumer model: acknowledges quiesce_req five cycles after seeing it.
  always @(negedge clk_osc) begin
    if (!rst) ackSr = '0;
    else      ackSr = {ackSr[3:0], oQuiesceReq};
    iQuiesceAck = ackEn & ackSr[4];
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] outs();
    return {oQuiesceReq, oStdby, oStdbyActive, oWakeEvt, oTimeoutErr};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    iStdbyReq = v.req;
    iWakeN    = v.wakeN;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk_osc);
      iStdbyReq = 1'b0;
    end
  endtask

  task automatic waitFor(input int idx, input int maxCycles, output int cnt);
    logic [4:0] o;
    cnt = 0;
    do begin
      @(negedge clk_osc);
      iStdbyReq = 1'b0;
      cnt++;
      o = outs();
    end while ((o[idx] !== 1'b1) && (cnt < maxCycles));
  endtask

  task automatic doReset();
    @(negedge clk_osc);
    iStdbyReq = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk_osc);
    rst = 1'b1;
    repeat (10) @(negedge clk_osc);
  endtask

  initial begin
    // {quiesce_req, stdby, stdby_active, wake_evt, timeout_err} sampled after each step
    vecs[0]  = '{"req_to_qreq",    1'b1, 1'b1, 1,  5'b10000};
    vecs[1]  = '{"pre_stdby",      1'b0, 1'b1, 7,  5'b10000};
    vecs[2]  = '{"stdby_rise",     1'b0, 1'b1, 1,  5'b11100};
    vecs[3]  = '{"dwell_hold",     1'b0, 1'b1, 70, 5'b11100};
    vecs[4]  = '{"debounce_pend",  1'b0, 1'b0, 17, 5'b11100};
    vecs[5]  = '{"wake_evt",       1'b0, 1'b0, 1,  5'b10010};
    vecs[6]  = '{"wake_pulse_end", 1'b0, 1'b1, 1,  5'b10000};
    vecs[7]  = '{"resume_pend",    1'b0, 1'b1, 30, 5'b10000};
    vecs[8]  = '{"qreq_fall",      1'b0, 1'b1, 1,  5'b00000};
    vecs[9]  = '{"req_in_resume",  1'b1, 1'b1, 20, 5'b00000};
    vecs[10] = '{"req_in_run",     1'b1, 1'b1, 1,  5'b10000};

    doReset();
    checkOutput("reset_outs", outs(), 5'b00000);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, outs(), vecs[i].exp);
    end

    // Timeout with a stray request mid-QUIESCE that must not restart the count
    doReset();
    ackEn = 1'b0;
    iStdbyReq = 1'b1;
    n = 0;
    sawStdby = 1'b0;
    do begin
      @(negedge clk_osc);
      n++;
      iStdbyReq = (n == 100);
      if (oStdby) sawStdby = 1'b1;
    end while (!oTimeoutErr && n < 1100);
    iStdbyReq = 1'b0;
    checkOutput("timeout_latency", n, 1025);
    checkOutput("timeout_qreq", oQuiesceReq, 1'b0);
    checkOutput("timeout_no_stdby", sawStdby, 1'b0);
    @(negedge clk_osc);
    checkOutput("timeout_pulse_end", oTimeoutErr, 1'b0);
    ackEn = 1'b1;

    // Early wake held from before entry: wake only once dwell completes
    doReset();
    iWakeN = 1'b0;
    repeat (5) @(negedge clk_osc);
    iStdbyReq = 1'b1;
    waitFor(3, 50, n);
    checkOutput("early_stdby_latency", n, 9);
    waitFor(1, 200, n);
    checkOutput("early_wake_dwell", n, 64);
    iWakeN = 1'b1;

    // Bouncing wake: 15 low, 1 high, 15 low must not wake; 16 low must
    doReset();
    iStdbyReq = 1'b1;
    waitFor(3, 50, n);
    checkOutput("bounce_stdby_latency", n, 9);
    repeat (70) @(negedge clk_osc);
    wakes = 0;
    for (int i = 0; i < 36; i++) begin
      iWakeN = !((i < 15) || ((i >= 16) && (i < 31)));
      @(negedge clk_osc);
      if (oWakeEvt) wakes++;
    end
    checkOutput("bounce_no_wake", wakes, 0);
    checkOutput("bounce_still_stdby", oStdby, 1'b1);
    iWakeN = 1'b0;
    waitFor(1, 50, n);
    checkOutput("debounce_latency", n, 18);
    checkOutput("debounce_outs", outs(), 5'b10010);
    iWakeN = 1'b1;

    // Async reset in STDBY drops stdby and quiesce_req with no clock edge
    doReset();
    iStdbyReq = 1'b1;
    waitFor(3, 50, n);
    repeat (3) @(negedge clk_osc);
    checkOutput("pre_reset_stdby", {oQuiesceReq, oStdby}, 2'b11);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset_drop", {oQuiesceReq, oStdby}, 2'b00);
    repeat (2) @(negedge clk_osc);
    rst = 1'b1;
    repeat (10) @(negedge clk_osc);
    checkOutput("post_reset_outs", outs(), 5'b00000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
